// File: rtl/div8x4_seq.sv
// Signed 8-bit / 4-bit restoring divider: one quotient bit per clock, then a
// sign-fix cycle. Results and flags are registered and held until the next fix.
module div8x4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       ovf,
  output logic       dbz
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t      state_q, state_d;
  logic        sign_n_q, sign_n_d;
  logic        sign_d_q, sign_d_d;
  logic        dbz_path_q, dbz_path_d;
  logic [7:0]  mag_n_q, mag_n_d;
  logic [3:0]  mag_d_q, mag_d_d;
  logic [4:0]  prem_q, prem_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  step_q, step_d;
  logic        done_q, done_d;
  logic [3:0]  quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic [4:0]        trial;
  logic              qbit;
  logic signed [8:0] qs;

  always_comb begin
    state_d    = state_q;
    sign_n_d   = sign_n_q;
    sign_d_d   = sign_d_q;
    dbz_path_d = dbz_path_q;
    mag_n_d    = mag_n_q;
    mag_d_d    = mag_d_q;
    prem_d     = prem_q;
    q_d        = q_q;
    step_d     = step_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    trial      = {prem_q[3:0], mag_n_q[7]};
    qbit       = 1'b0;
    qs         = (sign_n_q ^ sign_d_q) ? -$signed({1'b0, q_q}) : $signed({1'b0, q_q});

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_n_d   = dividend[7];
          sign_d_d   = divisor[3];
          // Unsigned negation maps -128 to 128 and -8 to 8, as wanted.
          mag_n_d    = dividend[7] ? -dividend : dividend;
          mag_d_d    = divisor[3] ? -divisor : divisor;
          prem_d     = '0;
          q_d        = '0;
          step_d     = '0;
          dbz_path_d = (divisor == 4'h0);
          state_d    = (divisor == 4'h0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        mag_n_d = mag_n_q << 1;
        if (trial >= {1'b0, mag_d_q}) begin
          prem_d = trial - {1'b0, mag_d_q};
          qbit   = 1'b1;
        end else begin
          prem_d = trial;
        end
        q_d    = {q_q[6:0], qbit};
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) state_d = S_FIX;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (dbz_path_q) begin
          quot_d = '0;
          rem_d  = '0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b1;
        end else begin
          ovf_d  = (qs < -9'sd8) || (qs > 9'sd7);
          quot_d = qs[3:0];
          rem_d  = sign_n_q ? -prem_q[3:0] : prem_q[3:0];
          dbz_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sign_n_q   <= 1'b0;
      sign_d_q   <= 1'b0;
      dbz_path_q <= 1'b0;
      mag_n_q    <= '0;
      mag_d_q    <= '0;
      prem_q     <= '0;
      q_q        <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_n_q   <= sign_n_d;
      sign_d_q   <= sign_d_d;
      dbz_path_q <= dbz_path_d;
      mag_n_q    <= mag_n_d;
      mag_d_q    <= mag_d_d;
      prem_q     <= prem_d;
      q_q        <= q_d;
      step_q     <= step_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div8x4_seq.sv
// Scoreboard bench for div8x4_seq: expected results are queued at each accepted
// start and compared against the outputs in the cycle done is due.
module tb_div8x4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, ovf, dbz;
  logic [3:0] quotient, remainder;

  div8x4_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dbz;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   cnt      = 0;
  bit   mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic signed [7:0] a, input logic signed [3:0] b, input int c);
    exp_t r;
    int ai, bi, qt, rt;
    ai = a;
    bi = b;
    if (bi == 0) begin
      r.q = 4'h0; r.r = 4'h0; r.ovf = 1'b0; r.dbz = 1'b1; r.due = c + 2;
    end else begin
      qt = ai / bi;
      rt = ai % bi;
      r.q = qt[3:0]; r.r = rt[3:0]; r.ovf = (qt < -8) || (qt > 7); r.dbz = 1'b0;
      r.due = c + 10;
    end
    return r;
  endfunction

  // Acceptance model: IDLE is re-entered 10 edges after a normal start, 2 after dbz.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      cnt <= 0;
      sb.delete();
    end else if (cnt == 0 && start) begin
      sb.push_back(model(dividend, divisor, cyc));
      cnt <= (divisor == 4'h0) ? 1 : 9;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("busy", {15'd0, busy}, {15'd0, cnt != 0});
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check_eq("done_due", {15'd0, done}, 16'd1);
        check_eq("quotient", {12'd0, quotient}, {12'd0, e.q});
        check_eq("remainder", {12'd0, remainder}, {12'd0, e.r});
        check_eq("ovf", {15'd0, ovf}, {15'd0, e.ovf});
        check_eq("dbz", {15'd0, dbz}, {15'd0, e.dbz});
      end else begin
        check_eq("done_idle", {15'd0, done}, 16'd0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && (sb.size() != 0 || cnt != 0); i++) @(posedge clk);
    check_eq("wait_timeout", 16'(sb.size()), 16'd0);
    #1;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [3:0] b);
    wait_idle();
    @(posedge clk); #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    wait_idle();
  endtask

  task automatic check_out(input string tag, input logic [3:0] q, input logic [3:0] r,
                           input logic o, input logic z);
    check_eq({tag, "_q"}, {12'd0, quotient}, {12'd0, q});
    check_eq({tag, "_r"}, {12'd0, remainder}, {12'd0, r});
    check_eq({tag, "_ovf"}, {15'd0, ovf}, {15'd0, o});
    check_eq({tag, "_dbz"}, {15'd0, dbz}, {15'd0, z});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(posedge clk); @(negedge clk);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
    check_eq("rst_done", {15'd0, done}, 16'd0);
    check_out("rst", 4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_one(8'hF9, 4'h2); check_out("m7d2", 4'hD, 4'hF, 1'b0, 1'b0);
    run_one(8'h38, 4'h8); check_out("56dm8", 4'h9, 4'h0, 1'b0, 1'b0);
    run_one(8'hF8, 4'h1); check_out("m8d1", 4'h8, 4'h0, 1'b0, 1'b0);
    run_one(8'h07, 4'hF); check_out("7dm1", 4'h9, 4'h0, 1'b0, 1'b0);
    run_one(8'h64, 4'h7); check_out("100d7", 4'hE, 4'h2, 1'b1, 1'b0);
    run_one(8'h80, 4'h8); check_out("m128dm8", 4'h0, 4'h0, 1'b1, 1'b0);
    run_one(8'h2A, 4'h0); check_out("dbz", 4'h0, 4'h0, 1'b0, 1'b1);

    // Start held high; operands change every cycle, only accepted ones count.
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      dividend = 8'($urandom);
      divisor  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_idle();

    // Reset in cycle 5 of an operation.
    @(posedge clk); #1;
    dividend = 8'h64; divisor = 4'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
    check_eq("mid_rst_done", {15'd0, done}, 16'd0);
    check_out("mid_rst", 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    run_one(8'h0F, 4'h4); check_out("15d4", 4'h3, 4'h3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
